// File: rtl/plane_bus_pkg.sv
// -----------------------------------------------------------------------------
// plane_bus_pkg
// Shared definitions for the plane controller bus writer: command bytes sent
// with rs=1, the sequencing FSM state type, and small helpers that map a
// sequencer state to its bus behaviour.
// No ports (package).
// -----------------------------------------------------------------------------
package plane_bus_pkg;

  // Command bytes understood by the plane controller (rs = 1).
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear memory, address -> 0
  localparam logic [7:0] CMD_ZERO_ADDR = 8'h02;  // address -> 0
  localparam logic [7:0] CMD_INC       = 8'h06;  // auto-increment after each data write
  localparam logic [7:0] CMD_PWM_OFF   = 8'h08;  // blank the outputs
  localparam logic [7:0] CMD_PWM_ON    = 8'h0C;  // enable the outputs
  localparam logic [7:0] CMD_SET_ADDR  = 8'h80;  // set address, low 7 bits = address

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_INC,
    ST_ADDR,
    ST_DATA,
    ST_PWM_ON,
    ST_CLR,
    ST_DONE
  } state_t;

  // States in which a bus transfer is in flight.
  function automatic logic is_transfer(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

  // Command byte issued by each command state; data and idle states return 0.
  function automatic logic [7:0] cmd_byte(input state_t s);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      ST_BLANK:  b = CMD_PWM_OFF;
      ST_INC:    b = CMD_INC;
      ST_ADDR:   b = CMD_SET_ADDR;
      ST_PWM_ON: b = CMD_PWM_ON;
      ST_CLR:    b = CMD_CLEAR;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/plane_bus_phy.sv
// -----------------------------------------------------------------------------
// plane_bus_phy
// Timing engine for a single bus transfer. While i_req is high the transfer
// runs SETUP (strobe low), HIGH (strobe high) and HOLD (strobe low) phases of
// PHASE_CYCLES clocks each (legal range 3..15). o_ack pulses in the last HOLD
// cycle; keeping i_req high across that cycle starts the next transfer with no
// gap. The source byte/rs are taken in the second SETUP cycle (cycle index 1)
// and held in registers until the next transfer's capture cycle.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   i_req        : transfer request, held high for the whole transfer
//   i_src_data   : byte to send, must be valid in the second SETUP cycle
//   i_src_rs     : rs to send, must be valid in the second SETUP cycle
//   o_ack        : last cycle of the current transfer
//   o_data_en    : bus strobe (registered, glitch-free)
//   o_data_out   : bus data
//   o_rs         : bus register select
// -----------------------------------------------------------------------------
module plane_bus_phy #(
  parameter int D_WIDTH      = 8,
  parameter int PHASE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [D_WIDTH-1:0] i_src_data,
  input  logic               i_src_rs,
  output logic               o_ack,
  output logic               o_data_en,
  output logic [D_WIDTH-1:0] o_data_out,
  output logic               o_rs
);

  // 3 * 15 - 1 = 44 fits in six bits.
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_CAPTURE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HIGH_FIRST = CNT_W'(PHASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HOLD_FIRST = CNT_W'(2 * PHASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(3 * PHASE_CYCLES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_data_en;
  logic [D_WIDTH-1:0] r_data;
  logic               r_rs;
  logic               w_capture;

  assign o_ack     = i_req && (r_cnt == CNT_LAST);
  assign w_capture = i_req && (r_cnt == CNT_CAPTURE);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_cnt_next = '0;
    if (i_req && !o_ack) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // The strobe is its own flop, loaded from the next count, so it never
  // decodes combinationally from a multi-bit counter and cannot glitch.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_data_en <= 1'b0;
      r_data    <= '0;
      r_rs      <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_data_en <= (w_cnt_next >= CNT_HIGH_FIRST) && (w_cnt_next < CNT_HOLD_FIRST);
      if (w_capture) begin
        r_data <= i_src_data;
        r_rs   <= i_src_rs;
      end
    end
  end

  // During the capture cycle the source is passed straight through so the
  // bus is already valid in the second SETUP cycle; afterwards the register
  // holds it through HOLD.
  assign o_data_en  = r_data_en;
  assign o_data_out = w_capture ? i_src_data : r_data;
  assign o_rs       = w_capture ? i_src_rs   : r_rs;

endmodule

// File: rtl/plane_bus_writer.sv
// -----------------------------------------------------------------------------
// plane_bus_writer
// Sequencer that loads a frame of PWM values from a frame buffer into a plane
// controller over a parallel strobe bus, or issues a clear-memory command.
// Frame load: [PWM_OFF] INC SET_ADDR(0) data x OUT_NUM PWM_ON.
// Clear:      CLEAR.
// Build option: define PLANE_BUS_BLANK_EN to prefix every frame load with a
// PWM_OFF (blank) command.
//
// Ports
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   start   : one-cycle frame-load request (ignored while busy)
//   clear   : one-cycle clear request (wins over start, ignored while busy)
//   rdAddr  : frame buffer read address
//   rdData  : frame buffer data, valid one cycle after rdAddr
//   dataOut : bus data
//   dataEn  : bus strobe, receiver acts on its falling edge
//   rs      : 1 = command byte, 0 = PWM data byte
//   busy    : sequence in progress
//   done    : one-cycle completion pulse
// -----------------------------------------------------------------------------
module plane_bus_writer
  import plane_bus_pkg::*;
#(
  parameter int OUT_NUM      = 64,
  parameter int D_WIDTH      = 8,
  parameter int C_WIDTH      = 5,
  parameter int PHASE_CYCLES = 4,
  localparam int A_WIDTH     = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  output logic [A_WIDTH-1:0] rdAddr,
  input  logic [C_WIDTH-1:0] rdData,
  output logic [D_WIDTH-1:0] dataOut,
  output logic               dataEn,
  output logic               rs,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] ADDR_LAST = A_WIDTH'(OUT_NUM - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [A_WIDTH-1:0] r_rd_addr;
  logic [A_WIDTH-1:0] w_rd_addr_next;
  logic               r_busy;
  logic               r_done;

  logic               w_req;
  logic               w_ack;
  logic [D_WIDTH-1:0] w_src_data;
  logic               w_src_rs;

  // Next-state logic. Requests are looked at only in IDLE, so anything
  // arriving while busy is dropped rather than queued.
  always_comb begin
    w_state_next   = r_state;
    w_rd_addr_next = r_rd_addr;
    unique case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_state_next = ST_CLR;
        end else if (start) begin
`ifdef PLANE_BUS_BLANK_EN
          w_state_next = ST_BLANK;
`else
          w_state_next = ST_INC;
`endif
        end
      end
      ST_BLANK:  if (w_ack) w_state_next = ST_INC;
      ST_INC:    if (w_ack) w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (w_ack) begin
          w_state_next   = ST_DATA;
          w_rd_addr_next = '0;
        end
      end
      ST_DATA: begin
        // The address moves on the edge that opens the next data transfer,
        // giving the buffer one cycle before the capture cycle.
        if (w_ack) begin
          if (r_rd_addr == ADDR_LAST) begin
            w_state_next = ST_PWM_ON;
          end else begin
            w_rd_addr_next = r_rd_addr + A_WIDTH'(1);
          end
        end
      end
      ST_PWM_ON: if (w_ack) w_state_next = ST_DONE;
      ST_CLR:    if (w_ack) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the
  // state register and stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rd_addr <= w_rd_addr_next;
      r_busy    <= is_transfer(w_state_next);
      r_done    <= (w_state_next == ST_DONE);
    end
  end

  // Byte source for the phy: the frame buffer word in DATA, otherwise the
  // command belonging to the current state.
  always_comb begin
    w_src_data = D_WIDTH'(cmd_byte(r_state));
    w_src_rs   = 1'b1;
    if (r_state == ST_DATA) begin
      w_src_data = D_WIDTH'(rdData);
      w_src_rs   = 1'b0;
    end
  end

  assign w_req = is_transfer(r_state);

  plane_bus_phy #(
    .D_WIDTH      (D_WIDTH),
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phy (
    .clk        (clk),
    .reset      (reset),
    .i_req      (w_req),
    .i_src_data (w_src_data),
    .i_src_rs   (w_src_rs),
    .o_ack      (w_ack),
    .o_data_en  (dataEn),
    .o_data_out (dataOut),
    .o_rs       (rs)
  );

  assign rdAddr = r_rd_addr;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_plane_bus_writer.sv
`timescale 1ns/1ps
module tb_plane_bus_writer;

  localparam int OUT_NUM        = 64;
  localparam int D_WIDTH        = 8;
  localparam int C_WIDTH        = 5;
  localparam int P              = 4;
  localparam int A_WIDTH        = 6;
  localparam int XFER_CYCLES    = 3 * P;
  localparam int TIMEOUT_CYCLES = 4000;
`ifdef PLANE_BUS_BLANK_EN
  localparam int FRAME_XFERS    = OUT_NUM + 4;
`else
  localparam int FRAME_XFERS    = OUT_NUM + 3;
`endif

  typedef logic [D_WIDTH:0] xfer_t;  // {rs, byte}

  logic               clk;
  logic               reset;
  logic               start;
  logic               clear;
  logic [A_WIDTH-1:0] rdAddr;
  logic [C_WIDTH-1:0] rdData;
  logic [D_WIDTH-1:0] dataOut;
  logic               dataEn;
  logic               rs;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;

  plane_bus_writer #(
    .OUT_NUM      (OUT_NUM),
    .D_WIDTH      (D_WIDTH),
    .C_WIDTH      (C_WIDTH),
    .PHASE_CYCLES (P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .clear   (clear),
    .rdAddr  (rdAddr),
    .rdData  (rdData),
    .dataOut (dataOut),
    .dataEn  (dataEn),
    .rs      (rs),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: registered read, data one cycle after the address.
  logic [C_WIDTH-1:0] fb_mem [OUT_NUM];
  always @(posedge clk) rdData <= fb_mem[rdAddr];

  // ---------------------------------------------------------------------------
  // Bus monitor: strobe width, setup/hold stability, and capture of each
  // completed transfer at the strobe's falling edge.
  // ---------------------------------------------------------------------------
  xfer_t rx_q[$];
  xfer_t exp_q[$];
  xfer_t hist [32];
  xfer_t held;
  int    hi_run    = 0;
  int    hold_left = 0;
  bit    stable;

  always @(negedge clk) begin
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {rs, dataOut};
    if (reset) begin
      hi_run    = 0;
      hold_left = 0;
    end else begin
      if (hold_left > 0) begin
        n_checks++;
        if (hist[0] === held) n_pass++;
        else $display("FAIL hold_stable: bus=%h, held %h", hist[0], held);
        hold_left--;
      end
      if (dataEn === 1'b1) begin
        hi_run++;
      end else if (hi_run != 0) begin
        n_checks++;
        if (hi_run == P) n_pass++;
        else $display("FAIL strobe_width: %0d cycles high, want %0d", hi_run, P);
        // Samples from the second SETUP cycle up to this first HOLD cycle.
        stable = 1'b1;
        for (int i = 1; i < 2 * P; i++) if (hist[i] !== hist[0]) stable = 1'b0;
        n_checks++;
        if (stable) n_pass++;
        else $display("FAIL setup_stable: bus=%h changed during setup/high", hist[0]);
        rx_q.push_back(hist[0]);
        held      = hist[0];
        hold_left = P - 1;
        hi_run    = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver model: a plane controller memory driven by the captured bytes.
  // ---------------------------------------------------------------------------
  logic [D_WIDTH-1:0] rx_mem [128];
  int                 rx_addr;
  bit                 rx_pwm;

  task automatic rx_apply();
    xfer_t x;
    while (rx_q.size() > 0) begin
      x = rx_q.pop_front();
      if (x[D_WIDTH]) begin
        if (x[D_WIDTH-1:0] == 8'h01) begin
          for (int k = 0; k < 128; k++) rx_mem[k] = '0;
          rx_addr = 0;
        end else if (x[D_WIDTH-1:0] == 8'h02) rx_addr = 0;
        else if (x[D_WIDTH-1:0] == 8'h08) rx_pwm = 1'b0;
        else if (x[D_WIDTH-1:0] == 8'h0C) rx_pwm = 1'b1;
        else if (x[7]) rx_addr = int'(x[6:0]);
        // 0x06 selects auto-increment, the only mode this model implements.
      end else begin
        rx_mem[rx_addr % 128] = x[D_WIDTH-1:0];
        rx_addr = (rx_addr + 1) % 128;
      end
    end
  endtask

  task automatic build_frame_expected();
    exp_q.delete();
`ifdef PLANE_BUS_BLANK_EN
    exp_q.push_back({1'b1, 8'h08});
`endif
    exp_q.push_back({1'b1, 8'h06});
    exp_q.push_back({1'b1, 8'h80});
    for (int k = 0; k < OUT_NUM; k++) exp_q.push_back({1'b0, D_WIDTH'(fb_mem[k])});
    exp_q.push_back({1'b1, 8'h0C});
  endtask

  function automatic int count_seq_diffs();
    int d = 0;
    if (rx_q.size() != exp_q.size()) d++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int rx_mem_diffs(input bit expect_zero);
    int d = 0;
    logic [D_WIDTH-1:0] want;
    for (int k = 0; k < OUT_NUM; k++) begin
      want = expect_zero ? {D_WIDTH{1'b0}} : D_WIDTH'(fb_mem[k]);
      if (rx_mem[k] !== want) d++;
    end
    return d;
  endfunction

  // Pulses the request, reports busy in the first cycle after acceptance and
  // the number of cycles from busy rising to done. poke_at != 0 fires a start
  // and later a clear while busy.
  task automatic do_request(input bit s, input bit c, input int poke_at,
                            output bit busy_now, output int cycles);
    @(posedge clk); #1;
    start = s;
    clear = c;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    busy_now = busy;
    cycles   = 0;
    while (cycles < TIMEOUT_CYCLES) begin
      @(negedge clk);
      cycles++;
      if (poke_at != 0) begin
        start = (cycles == poke_at);
        clear = (cycles == poke_at + 300);
      end
      if (done === 1'b1) break;
    end
    start = 1'b0;
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dataEn  === 1'b0) n_pass++; else $display("FAIL reset/dataEn: %b, want 0", dataEn);
    n_checks++; if (rs      === 1'b0) n_pass++; else $display("FAIL reset/rs: %b, want 0", rs);
    n_checks++; if (dataOut === '0)   n_pass++; else $display("FAIL reset/dataOut: %h, want 0", dataOut);
    n_checks++; if (rdAddr  === '0)   n_pass++; else $display("FAIL reset/rdAddr: %h, want 0", rdAddr);
    n_checks++; if (busy    === 1'b0) n_pass++; else $display("FAIL reset/busy: %b, want 0", busy);
    n_checks++; if (done    === 1'b0) n_pass++; else $display("FAIL reset/done: %b, want 0", done);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_frame(input string name, input int pattern, input int poke_at);
    bit busy_now;
    bit late_busy;
    int cycles;
    int diffs;
    for (int k = 0; k < OUT_NUM; k++)
      fb_mem[k] = (pattern == 1) ? C_WIDTH'(k) : C_WIDTH'($urandom);
    build_frame_expected();
    do_request(1'b1, 1'b0, poke_at, busy_now, cycles);
    n_checks++;
    if (busy_now === 1'b1) n_pass++;
    else $display("FAIL %s/busy_rise: busy=%b, want 1", name, busy_now);
    n_checks++;
    if (cycles == FRAME_XFERS * XFER_CYCLES) n_pass++;
    else $display("FAIL %s/latency: done after %0d cycles, want %0d", name, cycles, FRAME_XFERS * XFER_CYCLES);
    diffs = count_seq_diffs();
    n_checks++;
    if (diffs == 0) n_pass++;
    else $display("FAIL %s/transfer_seq: %0d transfers with %0d differences, want %0d transfers",
                  name, rx_q.size(), diffs, exp_q.size());
    @(negedge clk);
    n_checks++;
    if ({done, busy} === 2'b00) n_pass++;
    else $display("FAIL %s/done_pulse: done=%b busy=%b a cycle after done, want 0 0", name, done, busy);
    late_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) late_busy = 1'b1;
    end
    n_checks++;
    if (!late_busy && rx_q.size() == exp_q.size()) n_pass++;
    else $display("FAIL %s/idle_after: busy seen=%b, transfers=%0d, want 0 and %0d",
                  name, late_busy, rx_q.size(), exp_q.size());
    rx_apply();
    diffs = rx_mem_diffs(1'b0);
    n_checks++;
    if (diffs == 0) n_pass++;
    else $display("FAIL %s/rx_memory: %0d words differ from frame buffer, want 0", name, diffs);
    n_checks++;
    if (rx_pwm) n_pass++;
    else $display("FAIL %s/rx_pwm: pwm=%b, want 1", name, rx_pwm);
  endtask

  task automatic test_clear_priority();
    bit    busy_now;
    bit    late_busy;
    int    cycles;
    int    diffs;
    xfer_t want_x;
    want_x = {1'b1, 8'h01};
    do_request(1'b1, 1'b1, 0, busy_now, cycles);
    n_checks++;
    if (busy_now === 1'b1) n_pass++;
    else $display("FAIL clear/busy_rise: busy=%b, want 1", busy_now);
    n_checks++;
    if (cycles == XFER_CYCLES) n_pass++;
    else $display("FAIL clear/latency: done after %0d cycles, want %0d", cycles, XFER_CYCLES);
    n_checks++;
    if (rx_q.size() == 1 && rx_q[0] === want_x) n_pass++;
    else $display("FAIL clear/transfer_seq: %0d transfers (first %h), want 1 transfer %h",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : xfer_t'(0), want_x);
    late_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) late_busy = 1'b1;
    end
    n_checks++;
    if (!late_busy && rx_q.size() == 1) n_pass++;
    else $display("FAIL clear/start_dropped: busy seen=%b, transfers=%0d, want 0 and 1", late_busy, rx_q.size());
    rx_apply();
    diffs = rx_mem_diffs(1'b1);
    n_checks++;
    if (diffs == 0) n_pass++;
    else $display("FAIL clear/rx_memory: %0d words nonzero after clear, want 0", diffs);
  endtask

  task automatic test_reset_abort();
    int guard;
    bit saw_done;
    bit saw_busy;
    for (int k = 0; k < OUT_NUM; k++) fb_mem[k] = C_WIDTH'($urandom);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(rx_q.size() == 9 && dataEn === 1'b1) && guard < TIMEOUT_CYCLES);
    n_checks++;
    if (guard < TIMEOUT_CYCLES) n_pass++;
    else $display("FAIL abort/reach_xfer10: no HIGH phase of transfer 10 in %0d cycles, transfers=%0d",
                  guard, rx_q.size());
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dataEn, busy, done} === 3'b000) n_pass++;
    else $display("FAIL abort/after_reset: dataEn=%b busy=%b done=%b, want 0 0 0", dataEn, busy, done);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (FRAME_XFERS * XFER_CYCLES + 20) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    n_checks++;
    if (!saw_done && !saw_busy) n_pass++;
    else $display("FAIL abort/no_done: done seen=%b busy seen=%b, want 0 0", saw_done, saw_busy);
    n_checks++;
    if (rx_q.size() == 9) n_pass++;
    else $display("FAIL abort/transfer_count: %0d transfers, want 9", rx_q.size());
    rx_apply();
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    clear   = 1'b0;
    rx_addr = 0;
    rx_pwm  = 1'b0;
    for (int k = 0; k < 128; k++) rx_mem[k] = '0;
    test_reset();
    test_frame("frame_random", 0, 0);
    test_frame("frame_ramp", 1, 0);
    test_clear_priority();
    test_frame("busy_ignore", 0, 100);
    test_reset_abort();
    test_frame("restart", 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/plane_bus_writer.md
PLANE_BUS_WRITER -- requirements
Module: plane_bus_writer

Interface
REQ-001 SHALL have parameter OUT_NUM, default 64, number of PWM channels written per frame.
REQ-002 SHALL have parameter D_WIDTH, default 8, bus data width.
REQ-003 SHALL have parameter C_WIDTH, default 5, PWM value width.
REQ-004 SHALL have parameter PHASE_CYCLES, default 4, clk cycles per bus phase; legal range 3..15.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to load a full frame.
REQ-008 SHALL have port clear, input, 1, one-cycle request to issue the clear-memory command.
REQ-009 SHALL have port rdAddr, output, log2(OUT_NUM), frame buffer read address.
REQ-010 SHALL have port rdData, input, C_WIDTH, frame buffer data, valid one cycle after rdAddr.
REQ-011 SHALL have port dataOut, output, D_WIDTH, bus data to plane controller.
REQ-012 SHALL have port dataEn, output, 1, bus strobe; the receiver acts on its falling edge.
REQ-013 SHALL have port rs, output, 1, 1 = command byte, 0 = PWM data byte.
REQ-014 SHALL have port busy, output, 1, high from acceptance of a request until done.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a sequence completes.

Function
REQ-016 Each transfer SHALL consist of SETUP (dataEn=0), HIGH (dataEn=1) and HOLD (dataEn=0) phases of PHASE_CYCLES cycles each, i.e. 3*PHASE_CYCLES cycles.
REQ-017 dataOut and rs SHALL be stable from the second SETUP cycle through the last HOLD cycle.
REQ-018 FSM states SHALL be IDLE, BLANK, INC, ADDR, DATA, PWM_ON, CLR, DONE.
REQ-019 start in IDLE SHALL go to BLANK (when enabled, REQ-029) or else INC; command bytes: INC=0x06, ADDR=0x80, PWM_ON=0x0C, all with rs=1.
REQ-020 DATA SHALL issue OUT_NUM transfers with rs=0, word k = zero-extended rdData for rdAddr=k, k=0..OUT_NUM-1 ascending.
REQ-021 rdAddr SHALL be updated on the first SETUP cycle of each DATA transfer; rdData SHALL be captured into dataOut on the second.
REQ-022 clear in IDLE SHALL go to CLR, issuing one transfer of 0x01 with rs=1, then DONE.
REQ-023 start and clear asserted together in IDLE: clear SHALL win; start is dropped.
REQ-024 start/clear while busy SHALL be ignored, not queued.
REQ-025 DONE SHALL last one cycle, with done=1 and busy=0, then return to IDLE; busy SHALL rise the cycle after request acceptance.
REQ-026 dataEn SHALL never pulse outside the HIGH phase; no glitch between back-to-back transfers.

Reset
REQ-027 On reset: state=IDLE, dataEn=0, rs=0, dataOut=0, rdAddr=0, busy=0, done=0, phase counters=0.
REQ-028 Reset mid-transfer SHALL drive dataEn=0 the next cycle and abandon the sequence with no done pulse.

Configuration
REQ-029 Macro PLANE_BUS_BLANK_EN: defined -> a frame load SHALL begin with a BLANK transfer of 0x08 (rs=1, PWM off), giving OUT_NUM+4 transfers; undefined -> BLANK SHALL be skipped, OUT_NUM+3 transfers.

Structure
REQ-030 Package plane_bus_pkg SHALL hold the command byte constants (CMD_CLEAR=0x01, CMD_ZERO_ADDR=0x02, CMD_INC=0x06, CMD_PWM_OFF=0x08, CMD_PWM_ON=0x0C, CMD_SET_ADDR=0x80) and the FSM state enum.
REQ-031 Sub-module plane_bus_phy SHALL implement one transfer's phase timing with a req/ack handshake; plane_bus_writer holds the sequencing FSM.

Verification
REQ-032 With the macro undefined and PHASE_CYCLES=4, start pulse -> 67 transfers (0x06, 0x80, 64 data, 0x0C); done 804 cycles after busy rises.
REQ-033 With PLANE_BUS_BLANK_EN defined, start -> first transfer 0x08 rs=1, 68 transfers total, done after 816 cycles.
REQ-034 Frame buffer word k = k[4:0] -> data bytes 0x00..0x1F, 0x00..0x1F with rs=0; a receiver model's memory matches the frame buffer and PWM is enabled.
REQ-035 start and clear in the same cycle -> single 0x01 transfer, done after 12 cycles; a start pulse while busy -> no extra transfers.
REQ-036 Reset asserted in the HIGH phase of transfer 10 -> dataEn=0 next cycle, busy=0, no done; a following start -> a full clean sequence.
